// File: rtl/tt_um_emern_frame_sched_if.sv
// Write channel between the SPI frontend (master) and the frame scheduler (slave).
//   wr_valid  frontend write request
//   wr_ready  scheduler can accept a write this cycle
//   wr_addr   shadow register index
//   wr_data   write data, DW bits
interface tt_um_emern_frame_sched_if #(
  parameter int unsigned DW = 14
) ();
  logic          wr_valid;
  logic          wr_ready;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/tt_um_emern_frame_sched.sv
// Frame-synchronous parameter scheduler.
// Frontend writes go to a shadow register file; a commit request arms a swap
// that copies shadow to the active file on the first rising edge of
// screen_inactive, so the pixel core only ever sees a complete parameter set.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   wr               write channel (slave side)
//   commit_req       arm a shadow->active swap
//   irq_ack          clears irq, overrun and addr_err
//   screen_inactive  VGA blanking indicator
//   act_regs         active register file, reg i at [i*DW +: DW]
//   armed            commit pending
//   irq              level interrupt, set on commit completion
//   overrun          sticky: commit_req while already armed
//   addr_err         sticky: write to an index >= NUM_REGS
//   frame_cnt        completed commits, wraps
module tt_um_emern_frame_sched #(
  parameter int unsigned NUM_REGS = 10,
  parameter int unsigned DW       = 14,
  parameter int unsigned FCW      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  tt_um_emern_frame_sched_if.slave wr,
  input  logic                   commit_req,
  input  logic                   irq_ack,
  input  logic                   screen_inactive,
  output logic [NUM_REGS*DW-1:0] act_regs,
  output logic                   armed,
  output logic                   irq,
  output logic                   overrun,
  output logic                   addr_err,
  output logic [FCW-1:0]         frame_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_e;

  state_e                 state_q, state_d;
  logic                   prev_si_q, prev_si_d;
  logic [NUM_REGS*DW-1:0] shadow_q, shadow_d;
  logic [NUM_REGS*DW-1:0] act_q, act_d;
  logic                   irq_q, irq_d;
  logic                   overrun_q, overrun_d;
  logic                   addr_err_q, addr_err_d;
  logic [FCW-1:0]         frame_cnt_q, frame_cnt_d;

  logic vb_rise;
  logic wr_accept;

  assign vb_rise     = screen_inactive & ~prev_si_q;
  assign wr.wr_ready = (state_q != COMMIT);
  assign wr_accept   = wr.wr_valid & wr.wr_ready;

  always_comb begin
    state_d     = state_q;
    prev_si_d   = screen_inactive;
    shadow_d    = shadow_q;
    act_d       = act_q;
    irq_d       = irq_q;
    overrun_d   = overrun_q;
    addr_err_d  = addr_err_q;
    frame_cnt_d = frame_cnt_q;

    // Acknowledge first so that set events later in this block take priority.
    if (irq_ack) begin
      irq_d      = 1'b0;
      overrun_d  = 1'b0;
      addr_err_d = 1'b0;
    end

    if (wr_accept) begin
      if ({28'd0, wr.wr_addr} < NUM_REGS) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (wr.wr_addr == i[3:0]) shadow_d[i*DW +: DW] = wr.wr_data;
        end
      end else begin
        addr_err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (commit_req) state_d = vb_rise ? COMMIT : ARMED;
      end
      ARMED: begin
        if (commit_req) overrun_d = 1'b1;
        if (vb_rise)    state_d   = COMMIT;
      end
      COMMIT: begin
        // No writes are accepted here, so shadow_q is the complete set.
        act_d       = shadow_q;
        frame_cnt_d = frame_cnt_q + 1'b1;
        irq_d       = 1'b1;
        state_d     = commit_req ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_si_q   <= 1'b1;
      shadow_q    <= '0;
      act_q       <= '0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
      addr_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_si_q   <= prev_si_d;
      shadow_q    <= shadow_d;
      act_q       <= act_d;
      irq_q       <= irq_d;
      overrun_q   <= overrun_d;
      addr_err_q  <= addr_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign act_regs  = act_q;
  assign armed     = (state_q == ARMED);
  assign irq       = irq_q;
  assign overrun   = overrun_q;
  assign addr_err  = addr_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tt_um_emern_frame_sched.sv
module tb_tt_um_emern_frame_sched;
  localparam int NR  = 10;
  localparam int DW  = 14;
  localparam int FCW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic commit_req = 1'b0;
  logic irq_ack = 1'b0;
  logic screen_inactive = 1'b1;
  logic [NR*DW-1:0] act_regs;
  logic armed, irq, overrun, addr_err;
  logic [FCW-1:0] frame_cnt;

  tt_um_emern_frame_sched_if #(.DW(DW)) wr_if ();

  tt_um_emern_frame_sched #(.NUM_REGS(NR), .DW(DW), .FCW(FCW)) dut (
    .clk(clk), .rst(rst), .wr(wr_if),
    .commit_req(commit_req), .irq_ack(irq_ack), .screen_inactive(screen_inactive),
    .act_regs(act_regs), .armed(armed), .irq(irq), .overrun(overrun),
    .addr_err(addr_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a pending flag plus "a commit happens on the cycle
  // after blanking starts"; register files kept as plain arrays.
  logic [DW-1:0]  m_shadow [NR];
  logic [DW-1:0]  m_act    [NR];
  logic [FCW-1:0] m_cnt;
  bit m_pending, m_commit, m_irq, m_ovr, m_aerr, m_prev;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_shadow[i] = '0;
      m_act[i]    = '0;
    end
    m_cnt = '0; m_pending = 0; m_commit = 0;
    m_irq = 0; m_ovr = 0; m_aerr = 0; m_prev = 1;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    bit rise;
    logic [NR*DW-1:0] exp_act;
    if (rst) begin
      model_reset();
    end else begin
      rise = screen_inactive && !m_prev;
      if (irq_ack) begin m_irq = 0; m_ovr = 0; m_aerr = 0; end
      if (m_commit) begin
        m_act     = m_shadow;
        m_cnt     = m_cnt + 1'b1;
        m_irq     = 1;
        m_commit  = 0;
        m_pending = commit_req;
      end else begin
        if (wr_if.wr_valid) begin
          if (int'(wr_if.wr_addr) < NR) m_shadow[wr_if.wr_addr] = wr_if.wr_data;
          else m_aerr = 1;
        end
        if (commit_req && m_pending) m_ovr = 1;
        if (commit_req || m_pending) begin
          if (rise) begin m_commit = 1; m_pending = 0; end
          else m_pending = 1;
        end
      end
      m_prev = screen_inactive;
    end
    #1;
    if (!rst) begin
      for (int i = 0; i < NR; i++) exp_act[i*DW +: DW] = m_act[i];
      check("act_regs", act_regs, exp_act);
      check("frame_cnt", frame_cnt, m_cnt);
      check("irq", irq, m_irq);
      check("overrun", overrun, m_ovr);
      check("addr_err", addr_err, m_aerr);
      check("armed", armed, m_pending);
      check("wr_ready", wr_if.wr_ready, !m_commit);
    end
  end

  task automatic post();
    @(posedge clk); #1;
  endtask

  task automatic drv();
    @(negedge clk);
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;

    // 1: reset with blanking active, hold -> nothing happens
    repeat (3) drv();
    rst = 1'b0;
    repeat (5) post();
    check("t1_act", act_regs, '0);
    check("t1_irq", irq, 1'b0);
    check("t1_cnt", frame_cnt, 8'd0);

    // 2: basic commit, act visible two edges after the rise
    drv(); screen_inactive = 1'b0;
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 4'd3; wr_if.wr_data = 14'h1A5;
    post();
    drv(); wr_if.wr_valid = 1'b0; commit_req = 1'b1;
    post();
    check("t2_armed", armed, 1'b1);
    drv(); commit_req = 1'b0; screen_inactive = 1'b1;
    post();
    check("t2_act_early", act_regs[3*DW +: DW], 14'h0);
    drv();
    post();
    check("t2_act", act_regs[3*DW +: DW], 14'h1A5);
    check("t2_irq", irq, 1'b1);
    check("t2_cnt", frame_cnt, 8'd1);
    drv(); irq_ack = 1'b1;
    post();
    check("t2_irq_ack", irq, 1'b0);
    drv(); irq_ack = 1'b0;

    // 3: double commit_req -> overrun, single commit
    screen_inactive = 1'b0; commit_req = 1'b1;
    post();
    drv(); commit_req = 1'b0;
    post();
    drv(); commit_req = 1'b1;
    post();
    check("t3_overrun", overrun, 1'b1);
    drv(); commit_req = 1'b0; screen_inactive = 1'b1;
    post();
    drv();
    post();
    check("t3_cnt", frame_cnt, 8'd2);
    drv(); irq_ack = 1'b1;
    post();
    check("t3_ovr_clr", overrun, 1'b0);
    drv(); irq_ack = 1'b0;

    // 4: write on rise edge included; write held through COMMIT lands after
    screen_inactive = 1'b0; commit_req = 1'b1;
    post();
    drv(); commit_req = 1'b0; screen_inactive = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 4'd0; wr_if.wr_data = 14'h111;
    post();
    check("t4_ready_commit", wr_if.wr_ready, 1'b0);
    drv(); wr_if.wr_addr = 4'd5; wr_if.wr_data = 14'h2AA;
    post();
    check("t4_act0", act_regs[0 +: DW], 14'h111);
    check("t4_act5_old", act_regs[5*DW +: DW], 14'h0);
    check("t4_ready_after", wr_if.wr_ready, 1'b1);
    drv();
    post();
    check("t4_act5_hold", act_regs[5*DW +: DW], 14'h0);
    drv(); wr_if.wr_valid = 1'b0; screen_inactive = 1'b0; commit_req = 1'b1;
    post();
    drv(); commit_req = 1'b0; screen_inactive = 1'b1;
    post();
    drv();
    post();
    check("t4_act5_new", act_regs[5*DW +: DW], 14'h2AA);
    check("t4_cnt", frame_cnt, 8'd4);

    // 5: bad address, then frame counter wrap
    drv(); wr_if.wr_valid = 1'b1; wr_if.wr_addr = 4'd12; wr_if.wr_data = 14'h3FFF;
    post();
    check("t5_addr_err", addr_err, 1'b1);
    drv(); wr_if.wr_valid = 1'b0; irq_ack = 1'b1;
    post();
    check("t5_addr_err_clr", addr_err, 1'b0);
    drv(); irq_ack = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      screen_inactive = 1'b0;
      post();
      drv(); screen_inactive = 1'b1; commit_req = 1'b1;
      post();
      drv(); commit_req = 1'b0;
      post();
      if (i == 252) check("t5_wrap0", frame_cnt, 8'd0);
      drv();
    end
    check("t5_wrap_full", frame_cnt, 8'd4);

    // 6: reset while armed
    screen_inactive = 1'b0; commit_req = 1'b1;
    post();
    drv(); commit_req = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_armed_rst", armed, 1'b0);
    check("t6_act_rst", act_regs, '0);
    check("t6_irq_rst", irq, 1'b0);
    post();
    drv(); rst = 1'b0;
    post();
    drv(); screen_inactive = 1'b1;
    repeat (3) post();
    check("t6_cnt", frame_cnt, 8'd0);
    check("t6_act", act_regs, '0);
    check("t6_armed", armed, 1'b0);

    drv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: simulation did not complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
